// File: rtl/mips32_prog_harness.sv
// Run-control harness for mips32_pipeline: streams a program into instruction memory,
// releases the core until HLT or timeout, then streams the register file back out.
module mips32_prog_harness #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DUMP_REGS   = 32,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_init,
    output logic              core_run,
    input  logic              core_halted,
    output logic [4:0]        reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              dump_valid,
    output logic [4:0]        dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {StIdle, StLoad, StInit, StRun, StDump, StDone} state_e;

    localparam logic [ADDR_W-1:0] AddrMax    = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CntMax     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(TIMEOUT_CYC);
    localparam logic [5:0]        DumpN      = 6'(DUMP_REGS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic [5:0]        dcnt_q, dcnt_d;
    logic              dump_valid_q, dump_valid_d;
    logic [4:0]        dump_idx_q, dump_idx_d;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cyc_d        = cyc_q;
        timeout_d    = timeout_q;
        overflow_d   = overflow_q;
        dcnt_d       = dcnt_q;
        dump_valid_d = 1'b0;
        dump_idx_d   = dump_idx_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StLoad;
                    wcnt_d     = '0;
                    cyc_d      = '0;
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wcnt_q;
                    mem_wdata_d = ld_data;
                    if (ld_last) begin
                        state_d = StInit;
                    end else if (wcnt_q == AddrMax) begin
                        // Memory full: the word just written is forced to be the last one.
                        overflow_d = 1'b1;
                        state_d    = StInit;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            StInit: state_d = StRun;
            StRun: begin
                if (cyc_q != CntMax) cyc_d = cyc_q + 1'b1;
                if (core_halted) begin
                    state_d = StDump;
                    dcnt_d  = '0;
                end else if (cyc_d >= TimeoutVal) begin
                    timeout_d = 1'b1;
                    state_d   = StDump;
                    dcnt_d    = '0;
                end
            end
            StDump: begin
                // One extra cycle after the last address lets the final read word emerge.
                if (dcnt_q < DumpN) begin
                    dump_valid_d = 1'b1;
                    dump_idx_d   = dcnt_q[4:0];
                    dcnt_d       = dcnt_q + 6'd1;
                end else begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q      <= StIdle;
            wcnt_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cyc_q        <= '0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            dcnt_q       <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cyc_q        <= cyc_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
            dcnt_q       <= dcnt_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
        end
    end

    assign ld_ready    = (state_q == StLoad);
    assign core_init   = (state_q == StInit);
    assign core_run    = (state_q == StRun);
    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign done        = (state_q == StDone);
    assign reg_raddr   = ((state_q == StDump) && (dcnt_q < DumpN)) ? dcnt_q[4:0] : 5'd0;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dump_valid  = dump_valid_q;
    assign dump_idx    = dump_idx_q;
    assign dump_data   = dump_valid_q ? reg_rdata : '0;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mips32_prog_harness.sv
// Bench for mips32_prog_harness: a small behavioural core and memory answer the harness,
// while each scenario task checks the write, run and dump streams against expectations.
module tb_mips32_prog_harness;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned NREG  = 32;
    localparam int unsigned TO    = 64;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned OW    = 19 + AW + 2 * DW + CW;

    localparam logic [DW-1:0] NOM [9] = '{32'h2801000a, 32'h28020014, 32'h28030019,
        32'h0ce77800, 32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    localparam logic [DW-1:0] NOM_R [5] = '{32'd10, 32'd20, 32'd25, 32'd30, 32'd55};

    logic clk1 = 1'b0, rst = 1'b1, start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [DW-1:0] ld_data = '0, reg_rdata = '0;
    logic ld_ready, mem_we, core_init, core_run, core_halted, dump_valid;
    logic busy, done, timeout, overflow;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, dump_data;
    logic [4:0] reg_raddr, dump_idx;
    logic [CW-1:0] cycle_count;
    logic [OW-1:0] all_out;
    bit force_halt = 1'b0, mem_clear = 1'b0;

    int checks = 0, failures = 0, acked = 0, cyc = 0;
    logic [DW-1:0] prog [32];

    mips32_prog_harness #(
        .DATA_W(DW), .ADDR_W(AW), .DUMP_REGS(NREG), .TIMEOUT_CYC(TO), .CNT_W(CW)
    ) dut (
        .clk1(clk1), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_init(core_init), .core_run(core_run),
        .core_halted(core_halted), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data), .busy(busy),
        .done(done), .timeout(timeout), .overflow(overflow), .cycle_count(cycle_count)
    );

    always #5 clk1 = ~clk1;

    assign all_out = {ld_ready, mem_we, core_init, core_run, dump_valid, busy, done, timeout,
                      overflow, reg_raddr, dump_idx, mem_addr, mem_wdata, dump_data, cycle_count};

    // Behavioural core: one instruction per enabled cycle, HLT latches halted.
    logic [DW-1:0] imem [DEPTH];
    logic [DW-1:0] core_regs [32];
    logic [AW-1:0] pc = '0;
    logic halted_m = 1'b0;
    logic [DW-1:0] ir;
    assign ir = imem[pc];
    assign core_halted = halted_m | force_halt;

    always @(posedge clk1) begin
        reg_rdata <= core_regs[reg_raddr];
        if (mem_clear) begin
            for (int i = 0; i < int'(DEPTH); i++) imem[i] <= '0;
            for (int i = 0; i < 32; i++) core_regs[i] <= (i == 0) ? '0 : $urandom;
        end else begin
            if (mem_we) imem[mem_addr] <= mem_wdata;
            if (core_init) begin
                pc <= '0;
                halted_m <= 1'b0;
            end else if (core_run && !halted_m) begin
                pc <= pc + 1'b1;
                case (ir[31:26])
                    6'h00: if (ir[15:11] != 0)
                        core_regs[ir[15:11]] <= core_regs[ir[25:21]] + core_regs[ir[20:16]];
                    6'h03: if (ir[15:11] != 0)
                        core_regs[ir[15:11]] <= core_regs[ir[25:21]] | core_regs[ir[20:16]];
                    6'h0a: if (ir[20:16] != 0)
                        core_regs[ir[20:16]] <= core_regs[ir[25:21]] + {{16{ir[15]}}, ir[15:0]};
                    6'h3f: halted_m <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    int wq_addr[$], wq_cyc[$], dq_idx[$], dq_cyc[$], init_cyc[$];
    logic [DW-1:0] wq_data[$], dq_data[$];

    always @(negedge clk1) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            wq_addr.push_back(int'(mem_addr));
            wq_data.push_back(mem_wdata);
            wq_cyc.push_back(cyc);
        end
        if (dump_valid) begin
            dq_idx.push_back(int'(dump_idx));
            dq_data.push_back(dump_data);
            dq_cyc.push_back(cyc);
        end
        if (core_init) init_cyc.push_back(cyc);
    end

    task automatic clear_logs();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        dq_idx.delete(); dq_data.delete(); dq_cyc.delete(); init_cyc.delete();
    endtask

    task automatic prep();
        @(negedge clk1); mem_clear = 1'b1;
        @(negedge clk1); mem_clear = 1'b0;
        #1; clear_logs();
    endtask

    task automatic pulse_start();
        @(negedge clk1); start = 1'b1;
        @(negedge clk1); start = 1'b0;
    endtask

    // Offers prog[0..n-1]; stops once n words are taken or ld_ready stays low for 4 cycles.
    task automatic load_prog(input int n, input bit gaps, input int extra_start);
        int idx = 0, nr = 0;
        acked = 0;
        for (int k = 0; k < 400; k++) begin
            if (idx >= n || nr > 3) break;
            ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = prog[idx];
            ld_last  = (idx == n - 1);
            start    = (k == extra_start);
            if (ld_valid && ld_ready) begin
                idx++;
                acked++;
            end else if (!ld_ready) begin
                nr++;
            end
            @(negedge clk1);
        end
        ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk1);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    function automatic int write_errs();
        int e = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != i || wq_data[i] !== prog[i] || (i > 0 && wq_cyc[i] <= wq_cyc[i-1]))
                e++;
        return e;
    endfunction

    function automatic int dump_errs();
        int e = 0;
        for (int i = 0; i < dq_idx.size(); i++)
            if (dq_idx[i] != i || dq_data[i] !== core_regs[i] || dq_cyc[i] != dq_cyc[0] + i)
                e++;
        return e;
    endfunction

    function automatic int last_wcyc();
        return (wq_cyc.size() > 0) ? wq_cyc[wq_cyc.size()-1] : -1;
    endfunction

    function automatic int first_init();
        return (init_cyc.size() > 0) ? init_cyc[0] : -2;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; ld_valid = 1'b1; ld_data = $urandom;
        repeat (3) @(negedge clk1);
        checks++; if (all_out !== '0) begin failures++;
            $display("FAIL reset_outputs: got %h expected 0", all_out); end
        start = 1'b0; rst = 1'b0;
        prep();
        repeat (4) begin @(negedge clk1); ld_data = $urandom; end
        #1;
        checks++; if (wq_addr.size() != 0) begin failures++;
            $display("FAIL idle_ld_ignored: got %0d writes expected 0", wq_addr.size()); end
        checks++; if (busy !== 1'b0 || ld_ready !== 1'b0) begin failures++;
            $display("FAIL idle_state: got busy=%b ld_ready=%b expected 0 0", busy, ld_ready); end
        ld_valid = 1'b0;
    endtask

    task automatic test_nominal();
        bit ok;
        prep();
        for (int i = 0; i < 9; i++) prog[i] = NOM[i];
        pulse_start();
        load_prog(9, 1'b0, -1);
        wait_done(300, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL nominal_done: got done=%b expected 1", done); end
        checks++; if (wq_addr.size() != 9 || write_errs() != 0) begin failures++;
            $display("FAIL nominal_writes: got %0d writes %0d bad expected 9 0",
                     wq_addr.size(), write_errs()); end
        checks++; if (init_cyc.size() != 1 || first_init() != last_wcyc()) begin failures++;
            $display("FAIL nominal_init: got %0d pulses at %0d expected 1 at %0d",
                     init_cyc.size(), first_init(), last_wcyc()); end
        checks++; if (cycle_count !== 16'd10) begin failures++;
            $display("FAIL nominal_cycles: got %0d expected 10", cycle_count); end
        checks++; if (dq_idx.size() != NREG || dump_errs() != 0) begin failures++;
            $display("FAIL nominal_dump: got %0d words %0d bad expected %0d 0",
                     dq_idx.size(), dump_errs(), NREG); end
        for (int k = 1; k <= 5; k++) begin
            logic [DW-1:0] got;
            got = (dq_data.size() > k) ? dq_data[k] : '1;
            checks++; if (got !== NOM_R[k-1]) begin failures++;
                $display("FAIL nominal_r%0d: got %0d expected %0d", k, got, NOM_R[k-1]); end
        end
        checks++; if ({timeout, overflow, busy} !== 3'b000) begin failures++;
            $display("FAIL nominal_flags: got t/o/b=%b%b%b expected 000",
                     timeout, overflow, busy); end
    endtask

    task automatic test_timeout();
        bit ok;
        prep();
        prog[0] = 32'h0ce77800;
        pulse_start();
        load_prog(1, 1'b0, -1);
        wait_done(400, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL timeout_done: got done=%b expected 1", done); end
        checks++; if (cycle_count !== 16'(TO) || timeout !== 1'b1) begin failures++;
            $display("FAIL timeout_count: got %0d t=%b expected %0d t=1",
                     cycle_count, timeout, TO); end
        checks++; if (dq_idx.size() != NREG || dump_errs() != 0) begin failures++;
            $display("FAIL timeout_dump: got %0d words %0d bad expected %0d 0",
                     dq_idx.size(), dump_errs(), NREG); end
    endtask

    task automatic test_overflow();
        bit ok;
        prep();
        for (int i = 0; i < 18; i++) prog[i] = $urandom & 32'h03ff_ffff;
        pulse_start();
        load_prog(18, 1'b0, -1);
        wait_done(400, ok);
        checks++; if (acked != int'(DEPTH)) begin failures++;
            $display("FAIL overflow_acked: got %0d expected %0d", acked, DEPTH); end
        checks++; if (wq_addr.size() != DEPTH || write_errs() != 0) begin failures++;
            $display("FAIL overflow_writes: got %0d writes %0d bad expected %0d 0",
                     wq_addr.size(), write_errs(), DEPTH); end
        checks++; if (overflow !== 1'b1 || !ok) begin failures++;
            $display("FAIL overflow_flag: got ovf=%b done=%b expected 1 1", overflow, done); end
        checks++; if (first_init() != last_wcyc()) begin failures++;
            $display("FAIL overflow_init: got init at %0d expected %0d",
                     first_init(), last_wcyc()); end
    endtask

    task automatic test_gaps();
        bit ok;
        int n;
        for (int it = 0; it < 3; it++) begin
            prep();
            n = (it == 0) ? int'(DEPTH) : int'($urandom_range(4, DEPTH - 1));
            for (int i = 0; i < n - 1; i++) prog[i] = $urandom & 32'h03ff_ffff;
            prog[n-1] = 32'hfc000000;
            pulse_start();
            load_prog(n, 1'b1, (it == 1) ? 2 : -1);
            wait_done(400, ok);
            checks++; if (wq_addr.size() != n || write_errs() != 0) begin failures++;
                $display("FAIL gaps_writes[%0d]: got %0d writes %0d bad expected %0d 0",
                         it, wq_addr.size(), write_errs(), n); end
            checks++; if (!ok || overflow !== 1'b0 || timeout !== 1'b0) begin failures++;
                $display("FAIL gaps_flags[%0d]: got d/o/t=%b%b%b expected 100",
                         it, done, overflow, timeout); end
            checks++; if (init_cyc.size() != 1 || first_init() != last_wcyc()) begin failures++;
                $display("FAIL gaps_init[%0d]: got %0d pulses at %0d expected 1 at %0d",
                         it, init_cyc.size(), first_init(), last_wcyc()); end
            checks++; if (cycle_count !== 16'(n + 1)) begin failures++;
                $display("FAIL gaps_cycles[%0d]: got %0d expected %0d", it, cycle_count, n + 1); end
        end
    endtask

    task automatic test_simul_stop();
        bit ok, found = 1'b0;
        prep();
        prog[0] = 32'h0;
        pulse_start();
        load_prog(1, 1'b0, -1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk1);
            if (core_run && cycle_count == 16'(TO - 1)) begin
                found = 1'b1;
                break;
            end
        end
        force_halt = 1'b1;
        @(negedge clk1);
        force_halt = 1'b0;
        wait_done(200, ok);
        checks++; if (!found || !ok) begin failures++;
            $display("FAIL simul_reach: got found=%b done=%b expected 1 1", found, done); end
        checks++; if (timeout !== 1'b0 || cycle_count !== 16'(TO)) begin failures++;
            $display("FAIL simul_halt_wins: got t=%b count=%0d expected t=0 count=%0d",
                     timeout, cycle_count, TO); end
        checks++; if (dq_idx.size() != NREG) begin failures++;
            $display("FAIL simul_dump: got %0d words expected %0d", dq_idx.size(), NREG); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int ph = 0; ph < 2; ph++) begin
            prep();
            prog[0] = 32'h0;
            pulse_start();
            load_prog(1, 1'b0, -1);
            seen = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk1);
                if ((ph == 0) ? core_run : dump_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            rst = 1'b1;
            @(negedge clk1);
            checks++; if (!seen || all_out !== '0) begin failures++;
                $display("FAIL reset_mid[%0d]: got seen=%b out=%h expected 1 0", ph, seen, all_out); end
            rst = 1'b0;
            #1; clear_logs();
            repeat (5) @(negedge clk1);
            #1;
            checks++; if (dq_idx.size() != 0 || wq_addr.size() != 0 || busy || done) begin
                failures++;
                $display("FAIL reset_quiet[%0d]: got dumps=%0d writes=%0d busy=%b done=%b expected 0",
                         ph, dq_idx.size(), wq_addr.size(), busy, done); end
        end
    endtask

    task automatic test_restart();
        bit ok;
        int n;
        prep();
        prog[0] = 32'h0ce77800;
        pulse_start();
        load_prog(1, 1'b0, -1);
        repeat (3) @(negedge clk1);
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        checks++; if (core_run !== 1'b1 || ld_ready !== 1'b0) begin failures++;
            $display("FAIL restart_busy_ignored: got run=%b ready=%b expected 1 0",
                     core_run, ld_ready); end
        wait_done(400, ok);
        checks++; if (!ok || timeout !== 1'b1 || wq_addr.size() != 1 || init_cyc.size() != 1)
        begin failures++;
            $display("FAIL restart_first: got done=%b t=%b writes=%0d inits=%0d expected 1 1 1 1",
                     done, timeout, wq_addr.size(), init_cyc.size()); end
        prep();
        n = $urandom_range(2, 8);
        for (int i = 0; i < n - 1; i++) prog[i] = $urandom & 32'h03ff_ffff;
        prog[n-1] = 32'hfc000000;
        pulse_start();
        checks++; if ({done, timeout, busy, ld_ready} !== 4'b0011 || cycle_count !== '0) begin
            failures++;
            $display("FAIL restart_clear: got d/t/b/r=%b%b%b%b count=%0d expected 0011 0",
                     done, timeout, busy, ld_ready, cycle_count); end
        load_prog(n, 1'b1, -1);
        wait_done(400, ok);
        checks++; if (!ok || wq_addr.size() != n || write_errs() != 0) begin failures++;
            $display("FAIL restart_second: got done=%b writes=%0d bad=%0d expected 1 %0d 0",
                     done, wq_addr.size(), write_errs(), n); end
        checks++; if (cycle_count !== 16'(n + 1) || dump_errs() != 0) begin failures++;
            $display("FAIL restart_run: got count=%0d dump_bad=%0d expected %0d 0",
                     cycle_count, dump_errs(), n + 1); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_overflow();
        test_gaps();
        test_simul_stop();
        test_reset_mid();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips32_prog_harness.md
Name: mips32_prog_harness

Overview:
- Synthesizable run-control harness for the mips32_pipeline core.
- Replaces hierarchical memory/register poking with a stream-loaded program path, a core release/halt monitor with a timeout, and a register dump stream.
- Sits between a host or bench stream source and the core's instruction memory write port, control inputs and register-file debug read port.
- Parametrised in data width, memory depth, dump length and timeout.

Parameters:
- DATA_W, 32, instruction/register word width
- ADDR_W, 10, instruction memory address width; memory depth = 2**ADDR_W
- DUMP_REGS, 32, number of registers streamed out after the run (1..32)
- TIMEOUT_CYC, 4096, maximum RUN cycles before forced stop
- CNT_W, 16, width of cycle_count (must hold TIMEOUT_CYC)

Ports:
- clk1  in  1  single system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load/run/dump sequence; honoured in IDLE or DONE only
- ld_valid  in  1  program word valid
- ld_data  in  DATA_W  program word
- ld_last  in  1  marks the final program word
- ld_ready  out  1  harness accepts a word
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- core_init  out  1  one-cycle pulse: core clears PC, HALTED and TAKEN_BRANCH
- core_run  out  1  core enable
- core_halted  in  1  core has retired HLT
- reg_raddr  out  5  debug read address into the register file
- reg_rdata  in  DATA_W  debug read data, valid one cycle after reg_raddr
- dump_valid  out  1  dump word valid (1-cycle pulse per word)
- dump_idx  out  5  register index of dump_data
- dump_data  out  DATA_W  register value
- busy  out  1  state is not IDLE or DONE
- done  out  1  sequence complete; held until next start or rst
- timeout  out  1  RUN ended by timeout; held with done
- overflow  out  1  program truncated at memory depth; held with done
- cycle_count  out  CNT_W  RUN cycles used; held after RUN

Behaviour:
- Reset: every output is 0 and state = IDLE. Reset sampled mid-sequence aborts immediately: core_run drops on the same edge, and no further mem_we or dump_valid is issued.
- FSM states: IDLE, LOAD, INIT, RUN, DUMP, DONE.
- IDLE/DONE, start=1:
  - Go to LOAD.
  - Clear the word counter, cycle_count, done, timeout and overflow.
- LOAD:
  - ld_ready=1.
  - A handshake (ld_valid & ld_ready) registers mem_we=1, mem_addr=word counter and mem_wdata=ld_data on the next cycle (1-cycle latency); the counter then increments.
  - mem_we=0 when no handshake occurred.
  - ld_last accepted: go to INIT; ld_ready=0 from the next cycle.
  - Word accepted at address 2**ADDR_W-1 without ld_last: treat it as last, set overflow=1, go to INIT.
  - The counter never wraps.
- INIT:
  - Exactly one cycle, core_init=1.
  - The final mem_we of LOAD lands in this cycle.
- RUN:
  - core_run=1; cycle_count increments each cycle, saturating.
  - core_halted=1: next state DUMP, core_run=0 on the following cycle.
  - cycle_count reaching TIMEOUT_CYC: timeout=1, go to DUMP.
  - Both in the same cycle: halt wins, timeout stays 0.
- DUMP:
  - reg_raddr steps 0..DUMP_REGS-1, one index per cycle.
  - Each dump_valid is asserted one cycle after its reg_raddr, with dump_idx equal to that address and dump_data = reg_rdata.
  - Exactly DUMP_REGS pulses, on consecutive cycles; there is no backpressure.
  - After the last pulse, go to DONE.
- DONE: done=1; busy=0; outputs hold. start re-enters LOAD.
- start while busy: ignored.
- ld_valid outside LOAD: ignored, with no write.
- busy=1 in LOAD, INIT, RUN and DUMP.

Test Plan:
- Nominal program:
  - Stimulus: after rst, start, stream 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (last) with ld_valid held high.
  - Required: mem_we pulses at addresses 0..8; one core_init pulse; RUN ends on core_halted; 32 consecutive dump_valid pulses with R1=10, R2=20, R3=25, R4=30, R5=55; done=1, timeout=0.
- Timeout:
  - Stimulus: load a 1-word program 0ce77800 (no HLT), TIMEOUT_CYC=64.
  - Required: cycle_count=64, timeout=1, dump still streams DUMP_REGS words, done=1.
- Overflow:
  - Stimulus: ADDR_W=3, stream 10 words with ld_last on the 10th.
  - Required: exactly 8 writes to addresses 0..7, overflow=1, INIT entered after word 8, words 9 and 10 never acknowledged.
- Handshake gaps and simultaneous stop:
  - Stimulus: toggle ld_valid randomly during LOAD; separately, raise core_halted in the cycle cycle_count hits TIMEOUT_CYC.
  - Required: write addresses are contiguous with no duplicates; in the simultaneous case timeout=0.
- Reset and restart:
  - Stimulus: assert rst during RUN, then during DUMP; afterwards start twice (second start while busy).
  - Required: core_run=0 and all outputs 0 the cycle after the rst edge, no dump_valid after it; the second start is ignored; a fresh run completes normally and start from DONE reruns the sequence.
